// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array index generators.
// Holds the sweep FSM encoding and default bounds.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_MAX_WIDTH  = 32;
  localparam int DEF_MAX_HEIGHT = 32;
  localparam int DEF_MAX_TILES  = 16;
  localparam int DEF_ADDR_W     = 16;

  function automatic int clog_guard(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// One level of the nested sweep: counts 0..bound-1 and wraps.
// at_last feeds the incr of the next level up.
module wrap_counter #(
  parameter int W  = 5,
  parameter int BW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          incr,
  input  logic [BW-1:0] bound,
  output logic [W-1:0]  value,
  output logic          at_last
);

  assign at_last = (BW'(value) == bound - BW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (en && incr) begin
      value <= at_last ? '0 : value + W'(1);
    end
  end

endmodule

// File: rtl/tile_sweep_counter.sv
// Pixel -> slice -> tile sweep with latched bounds and incremental
// address generation for operand/result buffer indexing.
module tile_sweep_counter
  import systolic_pkg::*;
#(
  parameter int MAX_WIDTH  = DEF_MAX_WIDTH,
  parameter int MAX_HEIGHT = DEF_MAX_HEIGHT,
  parameter int MAX_TILES  = DEF_MAX_TILES,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int PW  = clog_guard(MAX_WIDTH),
  parameter int SW  = clog_guard(MAX_HEIGHT),
  parameter int TW  = clog_guard(MAX_TILES),
  parameter int CWW = $clog2(MAX_WIDTH + 1),
  parameter int CHW = $clog2(MAX_HEIGHT + 1),
  parameter int CTW = $clog2(MAX_TILES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CWW-1:0]    cfg_width,
  input  logic [CHW-1:0]    cfg_height,
  input  logic [CTW-1:0]    cfg_tiles,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic              ready,
  output logic              valid,
  output logic [PW-1:0]     pixel_cntr,
  output logic [SW-1:0]     slice_cntr,
  output logic [TW-1:0]     tile_cntr,
  output logic [ADDR_W-1:0] addr,
  output logic              last_pixel,
  output logic              last_slice,
  output logic              last,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam logic [CWW-1:0] MW = CWW'(MAX_WIDTH);
  localparam logic [CHW-1:0] MH = CHW'(MAX_HEIGHT);
  localparam logic [CTW-1:0] MT = CTW'(MAX_TILES);

  state_t state, state_nx;

  logic [CWW-1:0]    w_q;
  logic [CHW-1:0]    h_q;
  logic [CTW-1:0]    t_q;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] tstep_q;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] tile_base;
  logic [ADDR_W-1:0] addr_q;

  logic legal, accept, step, hs_last;
  logic px_last, sl_last, tl_last;

  assign legal = (cfg_width  != '0) && (cfg_width  <= MW) &&
                 (cfg_height != '0) && (cfg_height <= MH) &&
                 (cfg_tiles  != '0) && (cfg_tiles  <= MT);

  assign valid   = (state == RUN);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign accept  = (state == IDLE) && start && legal;
  assign hs_last = valid && ready && last;
  // Final beat does not advance, so counters keep their last values.
  assign step    = valid && ready && !last;

  assign last_pixel = valid && px_last;
  assign last_slice = last_pixel && sl_last;
  assign last       = last_slice && tl_last;
  assign addr       = addr_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)  state_nx = RUN;
      RUN:     if (hs_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  wrap_counter #(.W(PW), .BW(CWW)) u_px (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (step),
    .incr    (1'b1),
    .bound   (w_q),
    .value   (pixel_cntr),
    .at_last (px_last)
  );

  wrap_counter #(.W(SW), .BW(CHW)) u_sl (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (step),
    .incr    (px_last),
    .bound   (h_q),
    .value   (slice_cntr),
    .at_last (sl_last)
  );

  wrap_counter #(.W(TW), .BW(CTW)) u_tl (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (step),
    .incr    (px_last && sl_last),
    .bound   (t_q),
    .value   (tile_cntr),
    .at_last (tl_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q       <= '0;
      h_q       <= '0;
      t_q       <= '0;
      stride_q  <= '0;
      tstep_q   <= '0;
      row_base  <= '0;
      tile_base <= '0;
      addr_q    <= '0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= (state == IDLE) && start && !legal;
      if (accept) begin
        w_q       <= cfg_width;
        h_q       <= cfg_height;
        t_q       <= cfg_tiles;
        stride_q  <= cfg_stride;
        // Tile step computed once here so the sweep only adds.
        tstep_q   <= ADDR_W'(cfg_height) * cfg_stride;
        row_base  <= cfg_base;
        tile_base <= cfg_base;
        addr_q    <= cfg_base;
      end else if (step) begin
        if (px_last && sl_last) begin
          tile_base <= tile_base + tstep_q;
          row_base  <= tile_base + tstep_q;
          addr_q    <= tile_base + tstep_q;
        end else if (px_last) begin
          row_base  <= row_base + stride_q;
          addr_q    <= row_base + stride_q;
        end else begin
          addr_q    <= addr_q + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tile_sweep_counter.sv
// Bench for tile_sweep_counter: randomized ready/config sweeps
// compared beat by beat against an arithmetic index model.
module tb_tile_sweep_counter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  cfg_width;
  logic [5:0]  cfg_height;
  logic [4:0]  cfg_tiles;
  logic [15:0] cfg_base;
  logic [15:0] cfg_stride;
  logic        ready;
  logic        valid;
  logic [4:0]  pixel_cntr;
  logic [4:0]  slice_cntr;
  logic [3:0]  tile_cntr;
  logic [15:0] addr;
  logic        last_pixel;
  logic        last_slice;
  logic        last;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int n_chk  = 0;
  int n_fail = 0;

  tile_sweep_counter dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .cfg_tiles  (cfg_tiles),
    .cfg_base   (cfg_base),
    .cfg_stride (cfg_stride),
    .ready      (ready),
    .valid      (valid),
    .pixel_cntr (pixel_cntr),
    .slice_cntr (slice_cntr),
    .tile_cntr  (tile_cntr),
    .addr       (addr),
    .last_pixel (last_pixel),
    .last_slice (last_slice),
    .last       (last),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_cfg_err"}, 32'(cfg_err), 0);
    check({tag, "_pixel"}, 32'(pixel_cntr), 0);
    check({tag, "_slice"}, 32'(slice_cntr), 0);
    check({tag, "_tile"}, 32'(tile_cntr), 0);
    check({tag, "_addr"}, 32'(addr), 0);
    check({tag, "_flags"}, 32'({last_pixel, last_slice, last}), 0);
  endtask

  task automatic illegal(input int w, input int h, input int t);
    @(negedge clk);
    cfg_width  = 6'(w);
    cfg_height = 6'(h);
    cfg_tiles  = 5'(t);
    start      = 1'b1;
    ready      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("illegal_err", 32'(cfg_err), 1);
    check("illegal_busy", 32'(busy), 0);
    check("illegal_valid", 32'(valid), 0);
    @(negedge clk);
    check("illegal_err_pulse", 32'(cfg_err), 0);
    check("illegal_busy2", 32'(busy), 0);
  endtask

  // mode 0: ready high, 1: toggling, 2: random.
  task automatic sweep(input int w, input int h, input int t,
                       input logic [15:0] b, input logic [15:0] st,
                       input int mode, input int abort_at,
                       input bit scramble);
    int k = 0;
    int n = w * h * t;
    int cyc = 0;
    int p, s, tt, ea;
    bit rdy;
    @(negedge clk);
    cfg_width  = 6'(w);
    cfg_height = 6'(h);
    cfg_tiles  = 5'(t);
    cfg_base   = b;
    cfg_stride = st;
    start      = 1'b1;
    ready      = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("accept_busy", 32'(busy), 1);
    while (k < n && cyc < 5000) begin
      if (abort_at >= 0 && k == abort_at) begin
        rst = 1'b1;
        ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_zero("abort");
        return;
      end
      p  = k % w;
      s  = (k / w) % h;
      tt = k / (w * h);
      ea = (int'(b) + tt * h * int'(st) + s * int'(st) + p) % 65536;
      check("valid", 32'(valid), 1);
      check("pixel", 32'(pixel_cntr), 32'(p));
      check("slice", 32'(slice_cntr), 32'(s));
      check("tile", 32'(tile_cntr), 32'(tt));
      check("addr", 32'(addr), 32'(ea));
      check("last_pixel", 32'(last_pixel), 32'(p == w - 1));
      check("last_slice", 32'(last_slice), 32'(p == w - 1 && s == h - 1));
      check("last", 32'(last), 32'(k == n - 1));
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = (cyc % 2 == 0);
      else                rdy = 1'($urandom % 2);
      ready = rdy;
      if (scramble) begin
        cfg_width  = 6'($urandom);
        cfg_height = 6'($urandom);
        cfg_tiles  = 5'($urandom);
        cfg_base   = 16'($urandom);
        cfg_stride = 16'($urandom);
        start      = 1'($urandom % 2);
      end
      @(negedge clk);
      cyc++;
      if (rdy) k++;
    end
    check("sweep_complete", 32'(k), 32'(n));
    ready = 1'b0;
    check("done_pulse", 32'(done), 1);
    check("done_valid", 32'(valid), 0);
    check("done_busy", 32'(busy), 1);
    cfg_width  = 6'(w);
    cfg_height = 6'(h);
    cfg_tiles  = 5'(t);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_start_ignored_busy", 32'(busy), 0);
    check("done_start_ignored_valid", 32'(valid), 0);
    check("done_cleared", 32'(done), 0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    ready      = 1'b0;
    cfg_width  = '0;
    cfg_height = '0;
    cfg_tiles  = '0;
    cfg_base   = '0;
    cfg_stride = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    sweep(4, 3, 2, 16'h0100, 16'h0008, 0, -1, 1'b0);
    sweep(4, 3, 2, 16'h0100, 16'h0008, 1, -1, 1'b0);

    illegal(0, 3, 2);
    illegal(4, 3, 17);
    illegal(4, 33, 2);
    illegal(33, 1, 1);

    sweep(1, 1, 1, 16'h0040, 16'h0004, 0, -1, 1'b0);

    sweep(4, 3, 2, 16'h0100, 16'h0008, 0, 9, 1'b0);
    sweep(4, 3, 2, 16'h0100, 16'h0008, 0, -1, 1'b0);

    sweep(4, 3, 2, 16'hFFFE, 16'h0008, 2, -1, 1'b1);

    sweep(32, 2, 1, 16'hFFF0, 16'h0020, 2, -1, 1'b0);
    sweep(1, 32, 16, 16'h1234, 16'hF00D, 0, -1, 1'b0);

    repeat (6) begin
      sweep(int'($urandom_range(1, 32)), int'($urandom_range(1, 8)),
            int'($urandom_range(1, 4)), 16'($urandom), 16'($urandom),
            2, -1, 1'($urandom % 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
